// File: rtl/conv_bram_sr_pad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_bram_sr_pad : tap-serial 2-D convolution over BRAM-resident images,   |
// | zero padding, independent strides, RESULT_D parallel filters.              |
// | Optional ReLU on written results when CONV_BRAM_SR_PAD_RELU_EN is defined. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module conv_bram_sr_pad #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int IMG_D      = 4,
    parameter int FILTER_W   = 3,
    parameter int FILTER_H   = 3,
    parameter int RESULT_D   = 8,
    parameter int STRIDE_W   = 1,
    parameter int STRIDE_H   = 1,
    parameter int PAD        = 0,
    localparam int RESULT_W              = (IMG_W + 2*PAD - FILTER_W) / STRIDE_W + 1,
    localparam int RESULT_H              = (IMG_H + 2*PAD - FILTER_H) / STRIDE_H + 1,
    localparam int RES_WIDTH             = 4 * DATA_WIDTH,
    localparam int IMG_RAM_ADDR_WIDTH    = $clog2(IMG_W * IMG_H),
    localparam int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W * RESULT_H)
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [DATA_WIDTH*RESULT_D*IMG_D*FILTER_H*FILTER_W-1:0] fil,
    input  logic                                                   val_in,
    output logic                                                   rdy_in,
    output logic [IMG_RAM_ADDR_WIDTH*IMG_D-1:0]                    img_rdaddress,
    input  logic [DATA_WIDTH*IMG_D-1:0]                            img_data_in,
    output logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0]              result_wraddress,
    output logic [RES_WIDTH*RESULT_D-1:0]                          result_data_out,
    output logic [RESULT_D-1:0]                                    result_wren,
    output logic                                                   done
);

    localparam int TAPS  = FILTER_H * FILTER_W;
    localparam int OX_W  = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
    localparam int OY_W  = (RESULT_H > 1) ? $clog2(RESULT_H) : 1;
    localparam int FX_W  = (FILTER_W > 1) ? $clog2(FILTER_W) : 1;
    localparam int FY_W  = (FILTER_H > 1) ? $clog2(FILTER_H) : 1;
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [OX_W-1:0]  ox;
    logic [OY_W-1:0]  oy;
    logic [FX_W-1:0]  fx;
    logic [FY_W-1:0]  fy;
    logic             tap_v_d;
    logic             mask_d;
    logic [TAP_W-1:0] tap_d;

    logic signed [RES_WIDTH-1:0]    acc [RESULT_D];
    logic signed [RES_WIDTH-1:0]    sum [RESULT_D];
    logic signed [RES_WIDTH-1:0]    sum_tmp;
    logic signed [DATA_WIDTH-1:0]   wgt;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [RES_WIDTH-1:0]    res_val;

    int                                tx, ty;
    logic                              outside;
    logic [IMG_RAM_ADDR_WIDTH-1:0]     tap_addr;
    logic [RESULT_RAM_ADDR_WIDTH-1:0]  wr_addr;

    logic last_tap, last_px;
    assign last_tap = (fx == FX_W'(FILTER_W-1)) && (fy == FY_W'(FILTER_H-1));
    assign last_px  = (ox == OX_W'(RESULT_W-1)) && (oy == OY_W'(RESULT_H-1));

    // Tap position in image coordinates; padded taps read address 0 and are masked.
    always_comb begin
        tx       = int'(ox) * STRIDE_W + int'(fx) - PAD;
        ty       = int'(oy) * STRIDE_H + int'(fy) - PAD;
        outside  = (tx < 0) || (tx >= IMG_W) || (ty < 0) || (ty >= IMG_H);
        tap_addr = '0;
        if (state == S_FETCH && !outside) begin
            tap_addr = IMG_RAM_ADDR_WIDTH'(tx + ty * IMG_W);
        end
    end

    assign img_rdaddress = {IMG_D{tap_addr}};

    // Per-filter channel sum for the tap whose data is arriving this cycle.
    always_comb begin
        sum_tmp = '0;
        wgt     = '0;
        prod    = '0;
        for (int k = 0; k < RESULT_D; k++) begin
            sum_tmp = '0;
            for (int c = 0; c < IMG_D; c++) begin
                wgt     = $signed(fil[((k*IMG_D + c)*TAPS + int'(tap_d))*DATA_WIDTH +: DATA_WIDTH]);
                prod    = $signed(img_data_in[c*DATA_WIDTH +: DATA_WIDTH]) * wgt;
                sum_tmp = sum_tmp + {{(RES_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
            end
            sum[k] = sum_tmp;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (val_in)   state_nx = S_FETCH;
            S_FETCH: if (last_tap) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_WRITE;
            S_WRITE: state_nx = last_px ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ox      <= '0;
            oy      <= '0;
            fx      <= '0;
            fy      <= '0;
            tap_v_d <= 1'b0;
            mask_d  <= 1'b0;
            tap_d   <= '0;
            for (int k = 0; k < RESULT_D; k++) acc[k] <= '0;
        end else begin
            tap_v_d <= (state == S_FETCH);
            mask_d  <= outside;
            tap_d   <= TAP_W'(int'(fy) * FILTER_W + int'(fx));
            if (tap_v_d && !mask_d) begin
                for (int k = 0; k < RESULT_D; k++) acc[k] <= acc[k] + sum[k];
            end
            case (state)
                S_IDLE: begin
                    if (val_in) begin
                        ox <= '0;
                        oy <= '0;
                        fx <= '0;
                        fy <= '0;
                        for (int k = 0; k < RESULT_D; k++) acc[k] <= '0;
                    end
                end
                S_FETCH: begin
                    if (fx == FX_W'(FILTER_W-1)) begin
                        fx <= '0;
                        fy <= (fy == FY_W'(FILTER_H-1)) ? '0 : fy + 1'b1;
                    end else begin
                        fx <= fx + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (ox == OX_W'(RESULT_W-1)) begin
                        ox <= '0;
                        oy <= (oy == OY_W'(RESULT_H-1)) ? '0 : oy + 1'b1;
                    end else begin
                        ox <= ox + 1'b1;
                    end
                    for (int k = 0; k < RESULT_D; k++) acc[k] <= '0;
                end
                default: ;
            endcase
        end
    end

    assign rdy_in      = (state == S_IDLE);
    assign done        = (state == S_DONE);
    assign result_wren = {RESULT_D{state == S_WRITE}};

    always_comb begin
        wr_addr = '0;
        if (state == S_WRITE) begin
            wr_addr = RESULT_RAM_ADDR_WIDTH'(int'(ox) + int'(oy) * RESULT_W);
        end
    end

    assign result_wraddress = {RESULT_D{wr_addr}};

    always_comb begin
        result_data_out = '0;
        res_val         = '0;
        for (int k = 0; k < RESULT_D; k++) begin
`ifdef CONV_BRAM_SR_PAD_RELU_EN
            res_val = acc[k][RES_WIDTH-1] ? '0 : acc[k];
`else
            res_val = acc[k];
`endif
            if (state == S_WRITE) begin
                result_data_out[k*RES_WIDTH +: RES_WIDTH] = res_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_bram_sr_pad.sv
`default_nettype none
// Randomized bench for conv_bram_sr_pad: padded, strided, non-square, multi-channel
// configuration checked against a direct convolution model over a BRAM image model.
module tb_conv_bram_sr_pad;

    localparam int DW    = 8;
    localparam int IW    = 6;
    localparam int IH    = 5;
    localparam int ID    = 2;
    localparam int FW    = 3;
    localparam int FH    = 2;
    localparam int RD    = 3;
    localparam int SW    = 2;
    localparam int SH    = 1;
    localparam int PD    = 1;
    localparam int RW    = (IW + 2*PD - FW) / SW + 1;
    localparam int RH    = (IH + 2*PD - FH) / SH + 1;
    localparam int RES   = 4 * DW;
    localparam int AW    = $clog2(IW * IH);
    localparam int RAW   = $clog2(RW * RH);
    localparam int NPIX  = RW * RH;
    localparam int NT    = FW * FH;
    localparam int LAT   = NPIX * (NT + 2) + 1;
    localparam int LIM   = 4 * LAT;
    localparam int NWGT  = RD * ID * NT;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [DW*NWGT-1:0]    fil = '0;
    logic                  val_in = 1'b0;
    logic                  rdy_in;
    logic [AW*ID-1:0]      img_rdaddress;
    logic [DW*ID-1:0]      img_data_in = '0;
    logic [RAW*RD-1:0]     result_wraddress;
    logic [RES*RD-1:0]     result_data_out;
    logic [RD-1:0]         result_wren;
    logic                  done;

    int n_cmp = 0;
    int n_bad = 0;

    logic signed [DW-1:0]  img_mem [ID][1<<AW];
    logic [RAW*RD-1:0]     wa_q [$];
    logic [RES*RD-1:0]     wd_q [$];

    always #5 clk = ~clk;

    conv_bram_sr_pad #(
        .DATA_WIDTH (DW), .IMG_W (IW), .IMG_H (IH), .IMG_D (ID),
        .FILTER_W (FW), .FILTER_H (FH), .RESULT_D (RD),
        .STRIDE_W (SW), .STRIDE_H (SH), .PAD (PD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fil              (fil),
        .val_in           (val_in),
        .rdy_in           (rdy_in),
        .img_rdaddress    (img_rdaddress),
        .img_data_in      (img_data_in),
        .result_wraddress (result_wraddress),
        .result_data_out  (result_data_out),
        .result_wren      (result_wren),
        .done             (done)
    );

    always @(posedge clk) begin
        for (int c = 0; c < ID; c++) begin
            img_data_in[c*DW +: DW] <= img_mem[c][img_rdaddress[c*AW +: AW]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (result_wren != '0) begin
            check("wren_all", 64'(result_wren), 64'({RD{1'b1}}));
            wa_q.push_back(result_wraddress);
            wd_q.push_back(result_data_out);
        end
    end

    function automatic logic [RES-1:0] model(input int k, input int ox, input int oy);
        longint s = 0;
        logic signed [DW-1:0] w;
        for (int fy = 0; fy < FH; fy++) begin
            for (int fx = 0; fx < FW; fx++) begin
                int x = ox*SW + fx - PD;
                int y = oy*SH + fy - PD;
                if (x >= 0 && x < IW && y >= 0 && y < IH) begin
                    for (int c = 0; c < ID; c++) begin
                        w = fil[(((k*ID + c)*FH + fy)*FW + fx)*DW +: DW];
                        s += longint'(img_mem[c][x + y*IW]) * longint'(w);
                    end
                end
            end
        end
`ifdef CONV_BRAM_SR_PAD_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[RES-1:0];
    endfunction

    // mode 0: random, 1: image 1 / weights 1, 2: image 1 / weights -1
    task automatic set_data(input int mode);
        for (int c = 0; c < ID; c++)
            for (int a = 0; a < IW*IH; a++)
                img_mem[c][a] = (mode == 0) ? DW'($urandom) : DW'(1);
        for (int i = 0; i < NWGT; i++)
            fil[i*DW +: DW] = (mode == 0) ? DW'($urandom) : (mode == 1) ? DW'(1) : DW'(-1);
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!rdy_in && n < LIM) begin
            @(posedge clk); #1;
            n++;
        end
        check("rdy_wait", 64'(rdy_in), 64'(1));
    endtask

    task automatic run_job(input int mode, input bit hold);
        int cyc;
        int busy_rdy;
        logic [RAW*RD-1:0] wa;
        logic [RES*RD-1:0] wd;
        set_data(mode);
        wa_q.delete();
        wd_q.delete();
        wait_rdy();
        val_in = 1'b1;
        @(posedge clk); #1;
        if (!hold) val_in = 1'b0;
        cyc = 1;
        busy_rdy = 0;
        while (!done && cyc < LIM) begin
            if (rdy_in) busy_rdy++;
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(LAT));
        check("busy_rdy", 64'(busy_rdy), 64'(0));
        check("n_writes", 64'(wa_q.size()), 64'(NPIX));
        for (int i = 0; i < NPIX && i < wa_q.size(); i++) begin
            wa = wa_q[i];
            wd = wd_q[i];
            for (int k = 0; k < RD; k++) begin
                check("wr_addr", 64'(wa[k*RAW +: RAW]), 64'((i % RW) + (i / RW) * RW));
                check("wr_data", 64'(wd[k*RES +: RES]), 64'(model(k, i % RW, i / RW)));
            end
        end
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'(0));
        check("idle_rdy", 64'(rdy_in), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},   64'(rdy_in), 64'(1));
        check({tag, "_done"},  64'(done), 64'(0));
        check({tag, "_wren"},  64'(result_wren), 64'(0));
        check({tag, "_data"},  64'(result_data_out), 64'(0));
        check({tag, "_wa"},    64'(result_wraddress), 64'(0));
        check({tag, "_ra"},    64'(img_rdaddress), 64'(0));
    endtask

    initial begin
        int n;
        for (int c = 0; c < ID; c++)
            for (int a = 0; a < (1<<AW); a++)
                img_mem[c][a] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk) reset = 1'b1;

        run_job(1, 1'b0);
        run_job(2, 1'b0);
        run_job(0, 1'b0);
        run_job(0, 1'b0);

        // Mid-run reset after the second write
        set_data(0);
        wa_q.delete();
        wd_q.delete();
        wait_rdy();
        val_in = 1'b1;
        @(posedge clk); #1;
        val_in = 1'b0;
        n = 0;
        while (wa_q.size() < 2 && n < LIM) begin
            @(posedge clk); #1;
            n++;
        end
        check("two_writes", 64'(wa_q.size()), 64'(2));
        @(negedge clk) reset = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk) reset = 1'b1;
        wa_q.delete();
        wd_q.delete();
        repeat (6) @(posedge clk);
        #1;
        check("no_wr_after_rst", 64'(wa_q.size()), 64'(0));
        run_job(0, 1'b0);

        // val_in held high across back-to-back runs
        run_job(0, 1'b1);
        run_job(0, 1'b1);
        val_in = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_bram_sr_pad.md
CONV_BRAM_SR_PAD -- requirements
Module: conv_bram_sr_pad

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed pixel/weight width.
REQ-002 SHALL have parameters IMG_W, IMG_H, IMG_D, defaults 8, 8, 4: image width, height and channel count.
REQ-003 SHALL have parameters FILTER_W, FILTER_H, defaults 3, 3: filter width and height; non-square filters are allowed.
REQ-004 SHALL have parameter RESULT_D, default 8: number of filters.
REQ-005 SHALL have parameters STRIDE_W, STRIDE_H, defaults 1, 1: output stride.
REQ-006 SHALL have parameter PAD, default 0: zero-padding on every image edge.
REQ-007 SHALL derive the following and never set them externally:
- RESULT_W = (IMG_W+2*PAD-FILTER_W)/STRIDE_W+1
- RESULT_H likewise
- RES_WIDTH = 4*DATA_WIDTH
- IMG_RAM_ADDR_WIDTH = clog2(IMG_W*IMG_H)
- RESULT_RAM_ADDR_WIDTH = clog2(RESULT_W*RESULT_H)
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 fil  in  DATA_WIDTH*RESULT_D*IMG_D*FILTER_H*FILTER_W  weights; tap (k,c,fy,fx) at index ((k*IMG_D+c)*FILTER_H+fy)*FILTER_W+fx.
REQ-011 val_in  in  1  start request.
REQ-012 rdy_in  out  1  ready to accept a start.
REQ-013 img_rdaddress  out  IMG_RAM_ADDR_WIDTH*IMG_D  per-channel image BRAM read address, address = x+y*IMG_W.
REQ-014 img_data_in  in  DATA_WIDTH*IMG_D  channel c data at slice c; valid exactly 1 cycle after its address.
REQ-015 result_wraddress  out  RESULT_RAM_ADDR_WIDTH*RESULT_D  per-filter write address, address = ox+oy*RESULT_W.
REQ-016 result_data_out  out  RES_WIDTH*RESULT_D  filter k result at slice k.
REQ-017 result_wren  out  RESULT_D  per-filter write enable.
REQ-018 done  out  1  one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, DRAIN, WRITE, DONE.
REQ-020 SHALL assert rdy_in only in IDLE; a start is accepted on val_in&&rdy_in, and the FSM moves to FETCH with ox=oy=0 and accumulators cleared.
REQ-021 SHALL, in FETCH, issue one tap per cycle in order fy-major, fx-minor, T=FILTER_H*FILTER_W cycles, then move to DRAIN.
REQ-022 SHALL, for each tap, compute x=ox*STRIDE_W+fx-PAD and y=oy*STRIDE_H+fy-PAD; the address is driven identically on every channel slice.
REQ-023 SHALL, when a tap lies outside the image (x<0, x>=IMG_W, y<0 or y>=IMG_H), drive address 0 and mask that tap so it contributes exactly zero; the mask is delayed one cycle alongside the data.
REQ-024 SHALL, one cycle after each tap, add the sum over c of img_data_in[c]*fil[k,c,fy,fx] into acc[k] for every k in parallel.
- Inputs signed, products 2*DATA_WIDTH.
- Accumulators signed RES_WIDTH, wrapping modulo 2^RES_WIDTH.
REQ-025 SHALL use DRAIN (one cycle) to absorb the final tap's data, then WRITE.
REQ-026 SHALL, in WRITE, assert all result_wren bits for exactly one cycle, with result_data_out = acc and result_wraddress = ox+oy*RESULT_W on every slice.
REQ-027 SHALL, after WRITE, advance ox (wrapping to 0 and incrementing oy), clear the accumulators, and return to FETCH; after the last pixel it goes to DONE.
REQ-028 SHALL pulse done for one cycle in DONE, then return to IDLE; start-to-done latency = RESULT_W*RESULT_H*(T+2)+1 cycles.
REQ-029 SHALL ignore val_in outside IDLE; fil must be held stable from accept until done.
REQ-030 SHALL hold result_wren=0 outside WRITE.

Reset
REQ-031 SHALL, on reset low at any time (including mid-operation), immediately enter IDLE.
- rdy_in=1.
- done=0, result_wren=0.
- Addresses, result data, counters and accumulators 0.
REQ-032 SHALL, after reset release, write nothing until a new start is accepted.

Configuration
REQ-033 SHALL, with macro CONV_BRAM_SR_PAD_RELU_EN defined, drive result_data_out = (acc<0 ? 0 : acc) during WRITE.
REQ-034 SHALL, without CONV_BRAM_SR_PAD_RELU_EN, output the raw signed acc; no other behaviour differs.

Verification
REQ-035 IMG 4x4x1, 3x3 filter of all 1, image all 1, PAD=0 -> 4 writes at addresses 0..3, each value 9; done at cycle 4*11+1=45 after accept.
REQ-036 Same stimulus with PAD=1 -> 16 writes: corners 4, edges 6, interior 9.
REQ-037 IMG 5x5, STRIDE_W=STRIDE_H=2, image value x+y*5, single centre weight 1 -> outputs 0,2,4,10,12,14,20,22,24.
REQ-038 Weights all -1, image all 1, PAD=0 -> results -9 without the macro, 0 with CONV_BRAM_SR_PAD_RELU_EN.
REQ-039 Pull reset low after the 2nd write, release, restart -> all outputs 0 during reset, rdy_in=1, and a full correct sequence starting again at address 0.
REQ-040 Hold val_in=1 continuously -> exactly one run per IDLE visit, no accept while busy, rdy_in low from accept until done.
